// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel round-robin arbitrating mux with a registered valid/ready output stage.
// Define RRMUX_HOLD_EN to add in_hold, which lets the last granted channel keep the grant for bursts.
module rr_mux_reg #(
  parameter int WIDTH = 64,
  parameter int N = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
`ifdef RRMUX_HOLD_EN
  input  logic [N-1:0]       in_hold,
`endif
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);
  logic [SELW-1:0] rr_ptr, win, sel;
  logic any, load, take, hold_win;
  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] p, input int k);
    int j;
    j = int'(p) + k;
    return SELW'(j >= N ? j - N : j);
  endfunction
  // Scan from the far end so the channel nearest rr_ptr is written last and wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (in_valid[wrap_add(rr_ptr, k)]) begin
        win = wrap_add(rr_ptr, k);
        any = 1'b1;
      end
  end
`ifdef RRMUX_HOLD_EN
  logic granted;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) granted <= 1'b0;
    else if (load && take) granted <= 1'b1;
  assign hold_win = granted && in_valid[out_sel] && in_hold[out_sel];
`else
  assign hold_win = 1'b0;
`endif
  assign load = !out_valid || out_ready;
  assign sel = hold_win ? out_sel : win;
  assign take = hold_win || any;
  assign in_ready = (rst_n && load && take) ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      out_valid <= take;
      if (take) begin
        out_data <= in_data[sel*WIDTH +: WIDTH];
        out_sel <= sel;
        if (!hold_win) rr_ptr <= (sel == SELW'(N - 1)) ? '0 : sel + 1'b1;
      end
    end
endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: directed scoreboard bench for rr_mux_reg (N=4 main instance, N=3 wrap instance).
module tb_rr_mux_reg;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0] in_ready;
  logic out_valid, out_ready;
  logic [W-1:0] out_data;
  logic [1:0] out_sel;
  logic [2:0] in_valid3, in_ready3;
  logic [3*W-1:0] in_data3;
  logic out_valid3;
  logic [W-1:0] out_data3;
  logic [1:0] out_sel3;
  logic [3:0] in_hold;
  logic [W+1:0] q[$];
  logic [W+1:0] front;
  logic [2:0] e3[4];
  int ncmp = 0;
  int nfail = 0;
  always #5 clk = ~clk;
  rr_mux_reg #(.WIDTH(W), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef RRMUX_HOLD_EN
    .in_hold(in_hold),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready));
  rr_mux_reg #(.WIDTH(W), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_data(in_data3),
`ifdef RRMUX_HOLD_EN
    .in_hold(3'b000),
`endif
    .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
    .out_sel(out_sel3), .out_ready(1'b1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // One cycle: check grant, score the output word, record accepted input, advance past the edge.
  task automatic tick(input logic [3:0] er, input string tag);
    #1;
    chk({tag, "_ready"}, 32'(in_ready), 32'(er));
    if (out_valid === 1'b1) begin
      chk({tag, "_qnonempty"}, 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        front = q[0];
        chk({tag, "_word"}, 32'({out_sel, out_data}), 32'(front));
        if (out_ready) void'(q.pop_front());
      end
    end
    for (int i = 0; i < 4; i++)
      if (er[i] && in_valid[i]) q.push_back({2'(i), in_data[i*W +: W]});
    @(posedge clk);
    #1;
    chk({tag, "_ovalid"}, 32'(out_valid), 32'(q.size() != 0));
  endtask
  initial begin
    e3 = '{3'b001, 3'b010, 3'b100, 3'b001};
    rst_n = 1'b0;
    in_valid = 4'hf;
    in_hold = 4'h0;
    out_ready = 1'b1;
    in_valid3 = 3'b000;
    for (int i = 0; i < 4; i++) in_data[i*W +: W] = W'(i);
    for (int i = 0; i < 3; i++) in_data3[i*W +: W] = W'(16'h100 + i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    rst_n = 1'b1;
    tick(4'b0001, "rr0");
    tick(4'b0010, "rr1");
    tick(4'b0100, "rr2");
    tick(4'b1000, "rr3");
    tick(4'b0001, "rr4");
    tick(4'b0010, "rr5");
    tick(4'b0100, "rr6");
    in_valid = 4'b0100;
    in_data[2*W +: W] = 16'hDEAD;
    tick(4'b0100, "wrap_grant2");
    in_valid = 4'b0000;
    tick(4'b0000, "wrap_out");
    in_valid = 4'b1010;
    in_data[1*W +: W] = 16'h0011;
    in_data[3*W +: W] = 16'h0033;
    tick(4'b1000, "bp_fill");
    out_ready = 1'b0;
    tick(4'b0000, "bp_stall0");
    tick(4'b0000, "bp_stall1");
    tick(4'b0000, "bp_stall2");
    out_ready = 1'b1;
    tick(4'b0010, "bp_drain_refill");
    in_valid = 4'b0000;
    tick(4'b0000, "bp_drain");
    tick(4'b0000, "idle");
    in_valid = 4'b0101;
    tick(4'b0100, "ptr_after_idle");
    in_valid = 4'b0001;
    tick(4'b0001, "ptr_wrap0");
    in_valid = 4'b0000;
    tick(4'b0000, "drain2");
    in_valid = 4'b1000;
    tick(4'b1000, "pre_reset");
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    rst_n = 1'b1;
    in_valid = 4'hf;
    tick(4'b0001, "midrst_ptr0");
    in_valid = 4'b0000;
    tick(4'b0000, "midrst_drain");
    in_valid3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("n3_ready", 32'(in_ready3), 32'(e3[k]));
      @(posedge clk);
      #1;
      chk("n3_sel", 32'(out_sel3), 32'(k % 3));
      chk("n3_data", 32'(out_data3), 32'(16'h100 + k % 3));
    end
    in_valid3 = 3'b000;
`ifdef RRMUX_HOLD_EN
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 4; i++) in_data[i*W +: W] = W'(16'h200 + i);
    in_valid = 4'b0010;
    in_hold = 4'b0010;
    tick(4'b0010, "hold_b0");
    in_valid = 4'b0111;
    tick(4'b0010, "hold_b1");
    tick(4'b0010, "hold_b2");
    tick(4'b0010, "hold_b3");
    in_hold = 4'b0000;
    tick(4'b0100, "hold_release");
    in_valid = 4'b0000;
    tick(4'b0000, "hold_drain");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
